kernel_window_gen: RTL and testbench
====================================

# kernel_window_gen

Streaming 3x3 window generator on the coprocessor input path, upstream of the grayscale converter and kernel datapath. Accepts raster-order 12-bit RGB pixels over a valid/ready handshake and keeps two line buffers. For every interior center pixel it emits the three 36-bit kernel rows (top, center, bottom) that the converter consumes. It is the producer end of that 3-row kernel interface.

## Interface
- IMG_W, 640: image width in pixels, ≥3
- IMG_H, 480: image height in pixels, ≥3
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that begins a frame
- pix_in  in  12  RGB pixel, opaque to this block
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block accepts pix_in this cycle
- win_row0  out  36  top row, center y-1
- win_row1  out  36  center row, center y
- win_row2  out  36  bottom row, center y+1
- win_x  out  $clog2(IMG_W)  center column
- win_y  out  $clog2(IMG_H)  center row
- win_valid  out  1  window outputs valid
- win_ready  in  1  consumer takes the window
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at frame end

## Operation
- Row packing: [35:24] = column cx-1, [23:12] = cx, [11:0] = cx+1. win_row1[23:12] is the center pixel.
- Idle: busy=0, pix_ready=0. start sets busy=1 and clears the column counter x and row counter y to 0.
- Accept: pix_valid && pix_ready. pix_ready = busy && (!win_valid || win_ready).
- On each accept of pixel (x,y):
  - Read lb1[x] (row y-2) and lb0[x] (row y-1).
  - Shift column {lb1[x], lb0[x], pix_in} into the 3x3 window register. The newest column is the right column.
  - Write lb1[x] ← lb0[x] and lb0[x] ← pix_in.
  - Advance x. At x=IMG_W-1, wrap x to 0 and increment y.
- Window emit: if x≥2 and y≥2 at accept, load the output register with center (x-1, y-1) and set win_valid.
- Only interior centers are emitted: cx∈[1,IMG_W-2], cy∈[1,IMG_H-2], giving (IMG_W-2)(IMG_H-2) windows per frame.
- No window is emitted for the two column-0/1 pixels of each row, so stale columns from the previous row never reach the outputs.
- win_valid clears on a win_ready handshake unless a new window loads in the same cycle.
- Outputs are held stable while win_valid && !win_ready.
- Frame end:
  - After pixel (IMG_W-1, IMG_H-1) is accepted, pix_ready stays 0.
  - When the final window (IMG_W-2, IMG_H-2) is handshaken, the next cycle has busy=0 and frame_done=1 for exactly one cycle.
- start while busy restarts the frame: counters clear, win_valid clears, any pending window is dropped, and no frame_done is issued.
- start while idle and frame_done in the same cycle: start wins, busy stays 1.
- Line buffer contents are not reset.

## Timing
- Reset values: pix_ready=0, win_valid=0, busy=0, frame_done=0, win_row*=0, win_x=0, win_y=0.
- Reset mid-frame returns the block to idle next cycle. No frame_done is issued.
- Latency: win_valid rises the cycle after the accept of pixel (x,y) with x≥2 and y≥2.
- Throughput: 1 pixel/cycle sustained while win_ready=1.
- Backpressure stalls input with one window of buffering.
- pix_ready is registered-output friendly: it depends only on busy, win_valid and win_ready, never on pix_valid.
- Line buffers may use synchronous-read RAM with a lookahead address, provided the accept-to-win_valid latency above is unchanged.
- Frame end cycle count: frame_done is asserted 1 cycle after the last win handshake.

## Structure
- Shared package img_pkg:
  - PIX_W=12
  - typedef pixel_t = logic [11:0]
  - typedef krow_t = logic [35:0]
  - packing helper constants for the three slot offsets (24, 12, 0)
- Sub-module line_buffer: IMG_W×pixel_t single-port read-before-write memory, one instance per stored row (two instances).
- Counters, handshake control and the window/output registers stay in the top module.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, with pixel value = y*16+x.
- Streamed frame with pix_valid=1 and win_ready=1 -> exactly 4 windows in order (1,1),(2,1),(1,2),(2,2).
  - First window: win_row0=36'h000001002, win_row1=36'h010011012, win_row2=36'h020021022.
  - frame_done pulses once, 1 cycle after the 4th handshake.
- win_ready=0 for 5 cycles after the first window -> pix_ready=0 in those cycles, and outputs hold 36'h000001002/36'h010011012/36'h020021022 unchanged. After release, the sequence resumes with no loss or duplication.
- pix_valid toggling 1/0 every cycle -> same 4 windows and values. win_valid is seen 1 cycle after each qualifying accept.
- start pulse after 9 pixels of a frame -> no frame_done, win_valid=0 next cycle. A fresh full frame then yields the 4 correct windows.
- rst_n=0 for one cycle mid-frame -> all outputs at reset values next cycle. pix_ready stays 0 until start.
- pix_valid=1 with no start -> pix_ready=0 and no windows.

Source files
------------

// File: rtl/img_pkg.sv
// img_pkg: shared pixel and kernel-row types for the coprocessor input path.
// Exports the pixel/row widths, the three slot offsets of a kernel row,
// the column payload type, the window generator control states and a
// row packing helper.
package img_pkg;

  localparam int unsigned PIX_W  = 12;
  localparam int unsigned KROW_W = 3 * PIX_W;

  // Bit offsets of the left (cx-1), center (cx) and right (cx+1) slots.
  localparam int unsigned SLOT_L = 24;
  localparam int unsigned SLOT_C = 12;
  localparam int unsigned SLOT_R = 0;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [KROW_W-1:0] krow_t;

  // One vertical slice of the 3x3 window: rows y-2, y-1, y.
  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } column_t;

  // ST_DRAIN: every pixel of the frame is in, waiting for the last window.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Place three pixels into their slots of a kernel row.
  function automatic krow_t pack_row(input pixel_t left, input pixel_t center,
                                     input pixel_t right);
    krow_t row;
    row = '0;
    row[SLOT_L +: PIX_W] = left;
    row[SLOT_C +: PIX_W] = center;
    row[SLOT_R +: PIX_W] = right;
    return row;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row of pixels, single port, read-before-write.
// Ports:
//   clk   - write clock
//   we    - write enable
//   addr  - column address, shared by the read and the write
//   wdata - pixel written at addr on the rising edge when we=1
//   rdata - pixel currently stored at addr (old value during a write cycle)
// Contents are not reset.
module line_buffer
  import img_pkg::*;
#(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  pixel_t mem [DEPTH];

  // Asynchronous read returns the pre-write value in a write cycle.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/kernel_window_gen.sv
// kernel_window_gen: streaming 3x3 window generator.
// Accepts raster-order pixels and, for every interior center pixel, presents
// the top/center/bottom kernel rows to the downstream converter.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   start                - one-cycle frame start (restarts a frame in flight)
//   pix_in/pix_valid/pix_ready - pixel input handshake
//   win_row0/1/2         - kernel rows for center y-1, y, y+1
//   win_x/win_y          - center coordinates of the presented window
//   win_valid/win_ready  - window output handshake
//   busy                 - frame in progress
//   frame_done           - one-cycle pulse after the final window handshake
module kernel_window_gen
  import img_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [KROW_W-1:0]        win_row0,
  output logic [KROW_W-1:0]        win_row1,
  output logic [KROW_W-1:0]        win_row2,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_FIN  = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_FIN  = YW'(IMG_H - 2);

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  column_t       col_a;   // column x-2 relative to the incoming pixel
  column_t       col_b;   // column x-1 relative to the incoming pixel
  pixel_t        lb0_rd;  // row y-1 at column x
  pixel_t        lb1_rd;  // row y-2 at column x

  logic accept;
  logic emit;
  logic win_take;
  logic last_pix;
  logic last_win;

  assign busy      = (state != ST_IDLE);
  assign pix_ready = (state == ST_STREAM) && (!win_valid || win_ready);

  // A start in the same cycle restarts the frame, so the pixel is not taken.
  assign accept   = pix_valid && pix_ready && !start;
  assign emit     = accept && (x >= XW'(2)) && (y >= YW'(2));
  assign win_take = win_valid && win_ready;
  assign last_pix = (x == X_LAST) && (y == Y_LAST);
  assign last_win = win_take && (win_x == X_FIN) && (win_y == Y_FIN);

  // Row y-1 store; its old value cascades into the row y-2 store.
  line_buffer #(
    .DEPTH(IMG_W),
    .AW   (XW)
  ) u_lb0 (
    .clk  (clk),
    .we   (accept),
    .addr (x),
    .wdata(pix_in),
    .rdata(lb0_rd)
  );

  line_buffer #(
    .DEPTH(IMG_W),
    .AW   (XW)
  ) u_lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (x),
    .wdata(lb0_rd),
    .rdata(lb1_rd)
  );

  // Frame control, raster counters, window shift and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      x          <= '0;
      y          <= '0;
      col_a      <= '0;
      col_b      <= '0;
      win_row0   <= '0;
      win_row1   <= '0;
      win_row2   <= '0;
      win_x      <= '0;
      win_y      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        // Fresh or restarted frame: any pending window is dropped.
        state     <= ST_STREAM;
        x         <= '0;
        y         <= '0;
        win_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_STREAM: begin
            if (accept && last_pix) begin
              state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (last_win) begin
              state      <= ST_IDLE;
              frame_done <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase

        if (accept) begin
          col_a <= col_b;
          col_b <= {lb1_rd, lb0_rd, pix_in};
          if (x == X_LAST) begin
            x <= '0;
            y <= y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end

        // The incoming column is the right edge of the window centered at
        // (x-1, y-1); columns 0/1 never emit, so stale columns stay hidden.
        if (emit) begin
          win_row0  <= pack_row(col_a.top, col_b.top, lb1_rd);
          win_row1  <= pack_row(col_a.mid, col_b.mid, lb0_rd);
          win_row2  <= pack_row(col_a.bot, col_b.bot, pix_in);
          win_x     <= x - XW'(1);
          win_y     <= y - YW'(1);
          win_valid <= 1'b1;
        end else if (win_take) begin
          win_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_window_gen.sv
// Bench for kernel_window_gen on a 4x4 image: expected windows are cut
// directly from the frame image and compared on every output handshake.
module tb_kernel_window_gen;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [35:0] win_row0, win_row1, win_row2;
  logic [1:0]  win_x, win_y;
  logic        win_valid;
  logic        win_ready;
  logic        busy;
  logic        frame_done;

  kernel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win_row0  (win_row0),
    .win_row1  (win_row1),
    .win_row2  (win_row2),
    .win_x     (win_x),
    .win_y     (win_y),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [35:0] r0;
    logic [35:0] r1;
    logic [35:0] r2;
    int          x;
    int          y;
  } win_t;

  win_t exp_q[$];
  win_t e;
  bit   win_chk  = 0;
  int   mon_pos  = 0;
  bit   exp_done = 0;
  bit   pend     = 0;
  int   pend_x, pend_y;
  logic        p_valid = 0, p_ready = 0;
  logic [35:0] p_r0, p_r1, p_r2;
  logic [1:0]  p_x, p_y;

  // Per-cycle compare against the image-derived window list.
  always @(negedge clk) begin
    chk("frame_done", frame_done, exp_done);
    if (exp_done) chk("busy_at_done", busy, 0);
    exp_done = 0;
    if (win_chk) begin
      if (pend) begin
        chk("lat_valid", win_valid, 1);
        chk("lat_x", win_x, pend_x);
        chk("lat_y", win_y, pend_y);
      end
      if (p_valid && !p_ready) begin
        chk("hold_valid", win_valid, 1);
        chk("hold_row0", win_row0, p_r0);
        chk("hold_row1", win_row1, p_r1);
        chk("hold_row2", win_row2, p_r2);
        chk("hold_x", win_x, p_x);
        chk("hold_y", win_y, p_y);
      end
      if (win_valid && !win_ready) chk("bp_pix_ready", pix_ready, 0);
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL extra_window: got window (%0d,%0d) expected none", win_x, win_y);
        end else begin
          e = exp_q.pop_front();
          chk("win_row0", win_row0, e.r0);
          chk("win_row1", win_row1, e.r1);
          chk("win_row2", win_row2, e.r2);
          chk("win_x", win_x, e.x);
          chk("win_y", win_y, e.y);
          if (exp_q.size() == 0) exp_done = 1;
        end
      end
      pend = 0;
      if (pix_valid && pix_ready) begin
        if ((mon_pos % W) >= 2 && (mon_pos / W) >= 2) begin
          pend   = 1;
          pend_x = (mon_pos % W) - 1;
          pend_y = (mon_pos / W) - 1;
        end
        mon_pos++;
      end
    end else begin
      pend = 0;
    end
    p_valid = win_valid;
    p_ready = win_ready;
    p_r0 = win_row0;
    p_r1 = win_row1;
    p_r2 = win_row2;
    p_x  = win_x;
    p_y  = win_y;
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_row0"}, win_row0, 0);
    chk({tag, "_row1"}, win_row1, 0);
    chk({tag, "_row2"}, win_row2, 0);
    chk({tag, "_x"}, win_x, 0);
    chk({tag, "_y"}, win_y, 0);
  endtask

  // pat: 0 = y*16+x, 1 = random pixels
  // vmode: 0 = always valid, 1 = toggling, 2 = random
  // rmode: 0 = always ready, 1 = random, 2 = hold first window for 5 cycles
  // stop_after/abort_kind: abort after N pixels by 1 = start, 2 = reset
  task automatic run_frame(input int pat, input int vmode, input int rmode,
                           input int stop_after, input int abort_kind);
    logic [11:0] img[NPIX];
    win_t w;
    int  idx, stall, fd_cnt, hs_cnt;
    bit  first_seen, done;
    idx = 0; stall = 0; fd_cnt = 0; hs_cnt = 0; first_seen = 0; done = 0;
    for (int i = 0; i < NPIX; i++)
      img[i] = (pat == 0) ? 12'((i / W) * 16 + (i % W)) : 12'($urandom);
    exp_q.delete();
    for (int cy = 1; cy <= H - 2; cy++) begin
      for (int cx = 1; cx <= W - 2; cx++) begin
        w.r0 = {img[(cy-1)*W + cx-1], img[(cy-1)*W + cx], img[(cy-1)*W + cx+1]};
        w.r1 = {img[cy*W + cx-1],     img[cy*W + cx],     img[cy*W + cx+1]};
        w.r2 = {img[(cy+1)*W + cx-1], img[(cy+1)*W + cx], img[(cy+1)*W + cx+1]};
        w.x  = cx;
        w.y  = cy;
        exp_q.push_back(w);
      end
    end
    mon_pos   = 0;
    win_chk   = 1;
    pix_valid = 0;
    win_ready = 1;
    start     = 1;
    @(posedge clk); #1;
    start = 0;

    for (int c = 0; c < 400 && !done; c++) begin
      pix_valid = (idx < NPIX) &&
                  ((vmode == 0) ? 1'b1 :
                   (vmode == 1) ? (c % 2 == 0) : ($urandom_range(0, 3) != 0));
      pix_in = (idx < NPIX) ? img[idx] : 12'($urandom);
      case (rmode)
        0:       win_ready = 1'b1;
        1:       win_ready = ($urandom_range(0, 2) != 0);
        default: win_ready = (stall >= 5);
      endcase
      @(negedge clk);
      if (win_valid && !first_seen) begin
        first_seen = 1;
        if (pat == 0) begin
          chk("first_row0", win_row0, 36'h000001002);
          chk("first_row1", win_row1, 36'h010011012);
          chk("first_row2", win_row2, 36'h020021022);
          chk("first_x", win_x, 1);
          chk("first_y", win_y, 1);
        end
      end
      if (rmode == 2 && win_valid && stall < 5) begin
        stall++;
        chk("stall_pix_ready", pix_ready, 0);
        chk("stall_row0", win_row0, 36'h000001002);
        chk("stall_row1", win_row1, 36'h010011012);
        chk("stall_row2", win_row2, 36'h020021022);
      end
      if (win_valid && win_ready) hs_cnt++;
      if (pix_valid && pix_ready) idx++;
      if (frame_done) fd_cnt++;
      @(posedge clk); #1;
      if (fd_cnt > 0) done = 1;
      if (stop_after > 0 && idx >= stop_after) break;
    end

    if (stop_after > 0) begin
      win_chk   = 0;
      exp_q.delete();
      pix_valid = 0;
      win_ready = 0;
      if (abort_kind == 1) begin
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("restart_win_valid", win_valid, 0);
        chk("restart_busy", busy, 1);
        chk("restart_frame_done", frame_done, 0);
        repeat (4) @(posedge clk);
        #1;
      end else begin
        rst_n     = 0;
        pix_valid = 1;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk_reset_values("midrst");
        repeat (3) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk("postrst_pix_ready", pix_ready, 0);
          chk("postrst_win_valid", win_valid, 0);
        end
        @(posedge clk); #1;
        pix_valid = 0;
      end
    end else begin
      if (!done) begin
        vec++;
        miss++;
        $display("FAIL frame_timeout: got %0d pixels %0d windows, expected frame_done", idx, hs_cnt);
      end
      chk("frame_done_count", fd_cnt, 1);
      chk("window_count", hs_cnt, (W - 2) * (H - 2));
      chk("queue_drained", exp_q.size(), 0);
      pix_valid = 1;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_pix_ready", pix_ready, 0);
      @(posedge clk); #1;
      pix_valid = 0;
    end
  endtask

  initial begin
    rst_n = 0; start = 0; pix_valid = 0; pix_in = '0; win_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1;

    // No start: input must be refused.
    pix_valid = 1;
    win_ready = 1;
    repeat (4) begin
      @(negedge clk);
      chk("nostart_pix_ready", pix_ready, 0);
      chk("nostart_win_valid", win_valid, 0);
      chk("nostart_busy", busy, 0);
      @(posedge clk); #1;
    end
    pix_valid = 0;

    run_frame(0, 0, 0, 0, 0);   // streamed
    run_frame(0, 0, 2, 0, 0);   // 5-cycle hold on first window
    run_frame(0, 1, 0, 0, 0);   // toggling pix_valid
    run_frame(0, 0, 0, 9, 1);   // restart after 9 pixels
    run_frame(0, 0, 0, 0, 0);   // fresh frame after restart
    run_frame(1, 2, 1, 11, 1);  // restart with a window likely pending
    run_frame(1, 2, 1, 0, 0);
    run_frame(1, 0, 0, 7, 2);   // reset mid-frame
    run_frame(0, 0, 0, 0, 0);
    for (int f = 0; f < 12; f++) run_frame(1, 2, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
